vc_state_tracker: RTL and testbench
===================================

VC_STATE_TRACKER -- requirements
Module: vc_state_tracker

Interface
REQ-001 SHALL have parameter N_OF_REQUEST, default 6: number of requesters whose grants are observed.
REQ-002 SHALL have parameter N_TOT_OF_VC, default 6: total VCs (N_OF_VN*N_OF_VC).
REQ-003 SHALL have parameter BUFFER_DEPTH, default 4: router input-buffer slots (credits) per VC.
REQ-004 SHALL have parameter N_BITS_CREDIT, default 3: credit counter width, able to hold BUFFER_DEPTH.
REQ-005 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port g_vc_id_i  input  N_OF_REQUEST*N_TOT_OF_VC  VC-allocator grants, one-hot field per requester.
REQ-008 SHALL have port flit_valid_i  input  1  a flit leaves the NIC toward the router this cycle.
REQ-009 SHALL have port flit_vc_i  input  N_TOT_OF_VC  one-hot VC of the departing flit.
REQ-010 SHALL have port flit_tail_i  input  1  the departing flit is a tail, or a single-flit packet.
REQ-011 SHALL have port credit_valid_i  input  1  the router returns one credit this cycle.
REQ-012 SHALL have port credit_vc_i  input  N_TOT_OF_VC  one-hot VC of the returned credit.
REQ-013 SHALL have port fifo_pointer_state_o  output  N_TOT_OF_VC  bit i high means VC i is busy; feeds the VC allocator.
REQ-014 SHALL have port credit_avail_o  output  N_TOT_OF_VC  bit i high means VC i credit count is nonzero.
REQ-015 SHALL have port credit_count_o  output  N_TOT_OF_VC*N_BITS_CREDIT  registered credit count per VC, VC i at bits [i*N_BITS_CREDIT +: N_BITS_CREDIT].
REQ-016 SHALL have port error_o  output  1  sticky protocol-violation flag.

Function
REQ-017 SHALL maintain an independent FSM per VC with states IDLE, ACTIVE and DRAIN.
REQ-018 SHALL form alloc[i] as the OR over all requesters of g_vc_id_i bit i.
REQ-019 SHALL move a VC from IDLE to ACTIVE on a cycle where alloc[i]=1.
REQ-020 SHALL keep the state and set error_o when alloc[i]=1 arrives while the VC is ACTIVE or DRAIN.
REQ-021 SHALL treat a flit as sent on VC i when flit_valid_i=1, flit_vc_i[i]=1 and count[i]>0; count[i] then decrements by 1.
REQ-022 SHALL move VC i from ACTIVE to DRAIN when a sent flit has flit_tail_i=1; a single-flit packet takes the same transition.
REQ-023 SHALL ignore a flit (no count change, no state change) and set error_o when it targets a VC in IDLE or DRAIN, or a VC with count 0.
REQ-024 SHALL increment count[i] by 1 when credit_valid_i=1 and credit_vc_i[i]=1.
REQ-025 SHALL saturate count[i] at BUFFER_DEPTH and set error_o when a credit arrives at a count already equal to BUFFER_DEPTH.
REQ-026 SHALL leave count[i] unchanged when a valid send and a credit on the same VC occur in the same cycle.
REQ-027 SHALL move VC i from DRAIN to IDLE on a cycle where the registered count[i]==BUFFER_DEPTH, ensuring the downstream buffer is empty before reuse.
REQ-028 SHALL drive fifo_pointer_state_o[i]=1 exactly when the registered state is ACTIVE or DRAIN (Moore output, one cycle after the causing edge).
REQ-029 SHALL drive credit_avail_o[i] = (count[i]!=0), combinationally from the register.
REQ-030 SHALL set error_o on a flit_vc_i or credit_vc_i that is not one-hot while its valid is high, and ignore that event.
REQ-031 SHALL hold error_o high until reset once it is set.
REQ-032 SHALL process all VCs in parallel, so events on different VCs in the same cycle never interact.

Reset
REQ-033 SHALL, while rst=0, force every FSM to IDLE, every count to BUFFER_DEPTH and error_o to 0, independent of clk.
REQ-034 SHALL force outputs during reset to fifo_pointer_state_o=0, credit_avail_o=all ones and credit_count_o=BUFFER_DEPTH per field.
REQ-035 SHALL abandon mid-packet state when reset asserts mid-operation; state resumes from the reset values on the first edge after rst rises.

Verification
REQ-036 SHALL cover: reset, then grant on VC2 -> fifo_pointer_state_o=6'b000100 next cycle, count[2]=4.
REQ-037 SHALL cover: VC2 sends head, body, body, tail with no credits -> count 3,2,1,0; credit_avail_o[2]=0; state DRAIN; busy stays 1.
REQ-038 SHALL cover: the four credits for VC2 return one per cycle -> count reaches 4, state returns to IDLE the next cycle, busy clears the cycle after.
REQ-039 SHALL cover: a fifth flit on VC2 at count 0, then a credit at count 4 -> both ignored, count unchanged, error_o=1 and sticky.
REQ-040 SHALL cover: a simultaneous send and credit on VC0 at count 2 -> count stays 2, and a concurrent grant on VC5 takes VC5 to ACTIVE unaffected.
REQ-041 SHALL cover: rst asserted asynchronously mid-packet on VC3 -> all outputs reach reset values immediately, and VC3 is grantable again after rst rises.

Source files
------------

// File: rtl/vc_state_tracker.sv
// -----------------------------------------------------------------------------
// vc_state_tracker
//   NIC-side bookkeeping of the router's input virtual channels. Every VC has
//   its own IDLE/ACTIVE/DRAIN FSM and a credit counter that mirrors the free
//   slots of the matching router input buffer. A VC becomes busy when the VC
//   allocator grants it. It starts draining once its tail flit leaves. It is
//   released only after every credit has come back, so the downstream buffer
//   is known to be empty before the VC is reused.
//
// Ports
//   clk                  : single clock, rising-edge state updates
//   rst                  : asynchronous, active-low reset
//   g_vc_id_i            : VC-allocator grants, one N_TOT_OF_VC-wide one-hot
//                          field per requester
//   flit_valid_i         : a flit leaves toward the router this cycle
//   flit_vc_i            : one-hot VC of that flit
//   flit_tail_i          : that flit is a tail or a single-flit packet
//   credit_valid_i       : the router returns one credit this cycle
//   credit_vc_i          : one-hot VC of that credit
//   fifo_pointer_state_o : per-VC busy (ACTIVE or DRAIN)
//   credit_avail_o       : per-VC credit count is nonzero
//   credit_count_o       : per-VC credit count, VC i at [i*N_BITS_CREDIT +: N_BITS_CREDIT]
//   error_o              : sticky protocol-violation flag
// -----------------------------------------------------------------------------
module vc_state_tracker #(
  parameter int N_OF_REQUEST  = 6,
  parameter int N_TOT_OF_VC   = 6,
  parameter int BUFFER_DEPTH  = 4,
  parameter int N_BITS_CREDIT = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [N_OF_REQUEST*N_TOT_OF_VC-1:0]    g_vc_id_i,
  input  logic                                   flit_valid_i,
  input  logic [N_TOT_OF_VC-1:0]                 flit_vc_i,
  input  logic                                   flit_tail_i,
  input  logic                                   credit_valid_i,
  input  logic [N_TOT_OF_VC-1:0]                 credit_vc_i,
  output logic [N_TOT_OF_VC-1:0]                 fifo_pointer_state_o,
  output logic [N_TOT_OF_VC-1:0]                 credit_avail_o,
  output logic [N_TOT_OF_VC*N_BITS_CREDIT-1:0]   credit_count_o,
  output logic                                   error_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DRAIN  = 2'd2
  } state_t;

  localparam logic [N_BITS_CREDIT-1:0] DEPTH_C = N_BITS_CREDIT'(BUFFER_DEPTH);
  localparam logic [N_BITS_CREDIT-1:0] CNT_ONE = N_BITS_CREDIT'(1);
  localparam logic [N_TOT_OF_VC-1:0]   VC_ONE  = N_TOT_OF_VC'(1);

  function automatic logic is_onehot(input logic [N_TOT_OF_VC-1:0] v);
    return (v != '0) && ((v & (v - VC_ONE)) == '0);
  endfunction

  logic [N_TOT_OF_VC-1:0] alloc;
  logic [N_TOT_OF_VC-1:0] vc_err;
  logic                   flit_ok;
  logic                   credit_ok;
  logic                   flit_bad;
  logic                   credit_bad;
  logic                   error_reg;

  // A VC is allocated if any requester's grant field selects it.
  always_comb begin
    alloc = '0;
    for (int r = 0; r < N_OF_REQUEST; r++) begin
      alloc = alloc | g_vc_id_i[r*N_TOT_OF_VC +: N_TOT_OF_VC];
    end
  end

  // Events with a malformed VC vector are flagged and never reach any VC.
  assign flit_ok    = flit_valid_i & is_onehot(flit_vc_i);
  assign credit_ok  = credit_valid_i & is_onehot(credit_vc_i);
  assign flit_bad   = flit_valid_i & ~is_onehot(flit_vc_i);
  assign credit_bad = credit_valid_i & ~is_onehot(credit_vc_i);

  genvar gi;
  generate
    for (gi = 0; gi < N_TOT_OF_VC; gi++) begin : g_vc
      state_t                   state_reg;
      logic [N_BITS_CREDIT-1:0] count_reg;
      logic                     flit_hit;
      logic                     credit_hit;
      logic                     send;

      assign flit_hit   = flit_ok & flit_vc_i[gi];
      assign credit_hit = credit_ok & credit_vc_i[gi];
      // Only an ACTIVE VC with a free downstream slot may actually send.
      assign send       = flit_hit && (state_reg == ACTIVE) && (count_reg != '0);

      // A rejected flit, a credit that would overflow (unless a send in the
      // same cycle frees the slot) and a grant to a VC still in use are all
      // protocol violations.
      assign vc_err[gi] = (flit_hit & ~send)
                        | (credit_hit & ~send & (count_reg == DEPTH_C))
                        | (alloc[gi] & (state_reg != IDLE));

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          state_reg <= IDLE;
          count_reg <= DEPTH_C;
        end else begin
          // Send and credit together cancel out; the counter saturates at depth.
          if (send && !credit_hit) begin
            count_reg <= count_reg - CNT_ONE;
          end else if (credit_hit && !send && (count_reg != DEPTH_C)) begin
            count_reg <= count_reg + CNT_ONE;
          end

          case (state_reg)
            IDLE:    if (alloc[gi]) state_reg <= ACTIVE;
            ACTIVE:  if (send && flit_tail_i) state_reg <= DRAIN;
            // Release only once the registered count shows every slot free.
            DRAIN:   if (count_reg == DEPTH_C) state_reg <= IDLE;
            default: state_reg <= IDLE;
          endcase
        end
      end

      assign fifo_pointer_state_o[gi]                      = (state_reg != IDLE);
      assign credit_avail_o[gi]                            = (count_reg != '0);
      assign credit_count_o[gi*N_BITS_CREDIT +: N_BITS_CREDIT] = count_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      error_reg <= 1'b0;
    end else if ((|vc_err) | flit_bad | credit_bad) begin
      error_reg <= 1'b1;
    end
  end

  assign error_o = error_reg;

endmodule

// File: tb/tb_vc_state_tracker.sv
// -----------------------------------------------------------------------------
// tb_vc_state_tracker
//   Self-checking bench for vc_state_tracker with default parameters.
//   A table of {inputs, expected outputs} records is applied one per clock; the
//   expected record is queued when the stimulus is driven and popped and
//   compared one cycle later. Hand-written sequences cover the reset corners.
// -----------------------------------------------------------------------------
module tb_vc_state_tracker;

  localparam int NR = 6;
  localparam int NV = 6;
  localparam int NB = 3;

  logic              clk;
  logic              rst;
  logic [NR*NV-1:0]  g_vc_id_i;
  logic              flit_valid_i;
  logic [NV-1:0]     flit_vc_i;
  logic              flit_tail_i;
  logic              credit_valid_i;
  logic [NV-1:0]     credit_vc_i;
  logic [NV-1:0]     fifo_pointer_state_o;
  logic [NV-1:0]     credit_avail_o;
  logic [NV*NB-1:0]  credit_count_o;
  logic              error_o;

  vc_state_tracker #(
    .N_OF_REQUEST (NR),
    .N_TOT_OF_VC  (NV),
    .BUFFER_DEPTH (4),
    .N_BITS_CREDIT(NB)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .g_vc_id_i           (g_vc_id_i),
    .flit_valid_i        (flit_valid_i),
    .flit_vc_i           (flit_vc_i),
    .flit_tail_i         (flit_tail_i),
    .credit_valid_i      (credit_valid_i),
    .credit_vc_i         (credit_vc_i),
    .fifo_pointer_state_o(fifo_pointer_state_o),
    .credit_avail_o      (credit_avail_o),
    .credit_count_o      (credit_count_o),
    .error_o             (error_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit               rst_first;
    logic [NR*NV-1:0] g;
    logic             fv;
    logic [NV-1:0]    fvc;
    logic             ft;
    logic             cv;
    logic [NV-1:0]    cvc;
    logic [NV-1:0]    busy;
    logic [NV-1:0]    avail;
    logic [NV*NB-1:0] cnt;
    logic             err;
  } vec_t;

  typedef struct {
    int               id;
    logic [NV-1:0]    busy;
    logic [NV-1:0]    avail;
    logic [NV*NB-1:0] cnt;
    logic             err;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic logic [NV*NB-1:0] pk(input int c0, c1, c2, c3, c4, c5);
    return {NB'(c5), NB'(c4), NB'(c3), NB'(c2), NB'(c1), NB'(c0)};
  endfunction

  function automatic logic [NR*NV-1:0] gr(input int req, input int vc);
    logic [NR*NV-1:0] one;
    one = 1;
    return one << (req*NV + vc);
  endfunction

  function automatic vec_t mk(input bit r, input logic [NR*NV-1:0] g,
                              input logic fv, input logic [NV-1:0] fvc, input logic ft,
                              input logic cv, input logic [NV-1:0] cvc,
                              input logic [NV-1:0] busy, input logic [NV-1:0] avail,
                              input logic [NV*NB-1:0] cnt, input logic err);
    vec_t v;
    v.rst_first = r; v.g = g; v.fv = fv; v.fvc = fvc; v.ft = ft;
    v.cv = cv; v.cvc = cvc; v.busy = busy; v.avail = avail; v.cnt = cnt; v.err = err;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic [NV-1:0] busy,
                               input logic [NV-1:0] avail, input logic [NV*NB-1:0] cnt,
                               input logic err);
    chk({tag, " busy"},  64'(fifo_pointer_state_o), 64'(busy));
    chk({tag, " avail"}, 64'(credit_avail_o),       64'(avail));
    chk({tag, " count"}, 64'(credit_count_o),       64'(cnt));
    chk({tag, " error"}, 64'(error_o),              64'(err));
  endtask

  task automatic clear_inputs();
    g_vc_id_i      = '0;
    flit_valid_i   = 1'b0;
    flit_vc_i      = '0;
    flit_tail_i    = 1'b0;
    credit_valid_i = 1'b0;
    credit_vc_i    = '0;
  endtask

  // Called just after a rising edge; pulses reset between edges.
  task automatic pulse_reset();
    clear_inputs();
    rst = 1'b0;
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input int id, input vec_t v);
    exp_t e;
    string tag;
    if (v.rst_first) pulse_reset();
    g_vc_id_i      = v.g;
    flit_valid_i   = v.fv;
    flit_vc_i      = v.fvc;
    flit_tail_i    = v.ft;
    credit_valid_i = v.cv;
    credit_vc_i    = v.cvc;
    e.id = id; e.busy = v.busy; e.avail = v.avail; e.cnt = v.cnt; e.err = v.err;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: empty queue, expected 1 entry");
    end else begin
      e = sb.pop_front();
      tag = $sformatf("vec%0d", e.id);
      $display("%s: busy=%b avail=%b count=%h error=%b", tag,
               fifo_pointer_state_o, credit_avail_o, credit_count_o, error_o);
      check_outputs(tag, e.busy, e.avail, e.cnt, e.err);
    end
  endtask

  localparam logic [NV-1:0] ALL = 6'h3f;

  initial begin
    vec_t a;
    a = '{default: '0};
    // Grant on VC2 from requester 3, then a 4-flit packet, a stray fifth flit,
    // credits back one per cycle, release, and a credit at full count.
    tbl.push_back(mk(1, gr(3,2), 0, 6'h00, 0, 0, 6'h00, 6'h04, ALL,   pk(4,4,4,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h04, 0, 0, 6'h00, 6'h04, ALL,   pk(4,4,3,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h04, 0, 0, 6'h00, 6'h04, ALL,   pk(4,4,2,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h04, 0, 0, 6'h00, 6'h04, ALL,   pk(4,4,1,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h04, 1, 0, 6'h00, 6'h04, 6'h3b, pk(4,4,0,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h04, 0, 0, 6'h00, 6'h04, 6'h3b, pk(4,4,0,4,4,4), 1));
    tbl.push_back(mk(0, '0,      0, 6'h00, 0, 1, 6'h04, 6'h04, ALL,   pk(4,4,1,4,4,4), 1));
    tbl.push_back(mk(0, '0,      0, 6'h00, 0, 1, 6'h04, 6'h04, ALL,   pk(4,4,2,4,4,4), 1));
    tbl.push_back(mk(0, '0,      0, 6'h00, 0, 1, 6'h04, 6'h04, ALL,   pk(4,4,3,4,4,4), 1));
    tbl.push_back(mk(0, '0,      0, 6'h00, 0, 1, 6'h04, 6'h04, ALL,   pk(4,4,4,4,4,4), 1));
    tbl.push_back(mk(0, '0,      0, 6'h00, 0, 0, 6'h00, 6'h00, ALL,   pk(4,4,4,4,4,4), 1));
    tbl.push_back(mk(0, '0,      0, 6'h00, 0, 1, 6'h04, 6'h00, ALL,   pk(4,4,4,4,4,4), 1));
    // Credit overflow on its own after a fresh reset.
    tbl.push_back(mk(1, '0,      0, 6'h00, 0, 1, 6'h02, 6'h00, ALL,   pk(4,4,4,4,4,4), 1));
    // Two VCs active, then a non-one-hot flit touching both: ignored, error.
    tbl.push_back(mk(1, gr(0,0) | gr(1,1), 0, 6'h00, 0, 0, 6'h00, 6'h03, ALL, pk(4,4,4,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h03, 0, 0, 6'h00, 6'h03, ALL,   pk(4,4,4,4,4,4), 1));
    // VC0 to count 2, then send+credit on VC0 with a concurrent grant on VC5.
    tbl.push_back(mk(1, gr(5,0), 0, 6'h00, 0, 0, 6'h00, 6'h01, ALL,   pk(4,4,4,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h01, 0, 0, 6'h00, 6'h01, ALL,   pk(3,4,4,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h01, 0, 0, 6'h00, 6'h01, ALL,   pk(2,4,4,4,4,4), 0));
    tbl.push_back(mk(0, gr(2,5), 1, 6'h01, 0, 1, 6'h01, 6'h21, ALL,   pk(2,4,4,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h01, 1, 0, 6'h00, 6'h21, ALL,   pk(1,4,4,4,4,4), 0));
    // Grant to VC0 while it drains: error, state kept.
    tbl.push_back(mk(0, gr(4,0), 0, 6'h00, 0, 0, 6'h00, 6'h21, ALL,   pk(1,4,4,4,4,4), 1));
    // Async-reset scenario lead-in: VC3 mid-packet plus an error.
    tbl.push_back(mk(1, gr(1,3), 0, 6'h00, 0, 0, 6'h00, 6'h08, ALL,   pk(4,4,4,4,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h08, 0, 0, 6'h00, 6'h08, ALL,   pk(4,4,4,3,4,4), 0));
    tbl.push_back(mk(0, '0,      1, 6'h10, 0, 0, 6'h00, 6'h08, ALL,   pk(4,4,4,3,4,4), 1));

    // Reset state, checked while rst is held low.
    rst = 1'b0;
    clear_inputs();
    #12;
    check_outputs("reset", 6'h00, ALL, pk(4,4,4,4,4,4), 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      a = tbl[i];
      apply(i, a);
    end
    clear_inputs();

    // Reset asserted mid-cycle: outputs must change with no clock edge.
    #3;
    rst = 1'b0;
    #1;
    $display("async rst: busy=%b avail=%b count=%h error=%b",
             fifo_pointer_state_o, credit_avail_o, credit_count_o, error_o);
    check_outputs("async_rst", 6'h00, ALL, pk(4,4,4,4,4,4), 1'b0);
    // A grant while reset is held must be ignored across clock edges.
    g_vc_id_i = gr(0,3);
    @(posedge clk);
    #1;
    check_outputs("rst_held", 6'h00, ALL, pk(4,4,4,4,4,4), 1'b0);
    clear_inputs();
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    // VC3 is grantable again.
    a = mk(0, gr(0,3), 0, 6'h00, 0, 0, 6'h00, 6'h08, ALL, pk(4,4,4,4,4,4), 0);
    apply(100, a);
    clear_inputs();

    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard: %0d entries left, expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
